// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Sequences the fetch PC and the instruction-memory req/ack port. It issues
//   one request per instruction and hands the fetched word to decode. It
//   honours decode stall and applies jump/branch redirects, including
//   redirects that arrive while a fetch is still outstanding.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   imem_req, imem_addr         fetch request and address to instruction memory
//   imem_ack, imem_rdata        memory response strobe and instruction word
//   instr_valid, instr, instr_pc  delivered instruction towards decode
//   stall                       decode cannot accept; hold delivered instruction
//   jump, jump_target           unconditional redirect (higher priority)
//   branch_taken, branch_target taken-branch redirect
//   misalign                    sticky: a redirect target had bits[1:0] != 0
//   fault                       sticky: no ack within MAX_WAIT fetch cycles
module fetch_sequencer #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_ADDR = '0,
    parameter int unsigned          MAX_WAIT   = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              misalign,
    output logic              fault
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_DELIVER,
        S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    // Address currently presented to memory. It follows pc, except while a
    // killed request is still outstanding. In that case it keeps the old
    // address until the stale ack returns.
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         instr_q, instr_d;
    logic [ADDR_W-1:0]   ipc_q, ipc_d;
    logic                mis_q, mis_d;
    logic                fault_q, fault_d;
    logic                kill_q, kill_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                redir;
    logic [ADDR_W-1:0]   raw_tgt;
    logic [ADDR_W-1:0]   tgt;
    logic                tgt_mis;

    always_comb begin
        redir   = jump | branch_taken;
        raw_tgt = jump ? jump_target : branch_target;
        tgt     = {raw_tgt[ADDR_W-1:2], 2'b00};
        tgt_mis = |raw_tgt[1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_ADDR;
            addr_q  <= RESET_ADDR;
            instr_q <= '0;
            ipc_q   <= '0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
            kill_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            mis_q   <= mis_d;
            fault_q <= fault_d;
            kill_q  <= kill_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        mis_d   = mis_q;
        fault_d = fault_q;
        kill_d  = kill_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
                cnt_d   = '0;
            end

            S_FETCH: begin
                if (imem_ack) begin
                    cnt_d = '0;
                    if (kill_q) begin
                        // Stale response for a redirected request: drop it
                        // and start issuing the redirected pc.
                        kill_d = 1'b0;
                        if (redir) begin
                            pc_d   = tgt;
                            addr_d = tgt;
                            mis_d  = mis_q | tgt_mis;
                        end else begin
                            addr_d = pc_q;
                        end
                    end else if (redir) begin
                        pc_d   = tgt;
                        addr_d = tgt;
                        mis_d  = mis_q | tgt_mis;
                    end else begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_q;
                        pc_d    = pc_q + ADDR_W'(4);
                        addr_d  = pc_q + ADDR_W'(4);
                        state_d = S_DELIVER;
                    end
                end else begin
                    if (redir) begin
                        pc_d   = tgt;
                        kill_d = 1'b1;
                        mis_d  = mis_q | tgt_mis;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end
                end
            end

            S_DELIVER: begin
                if (!stall) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    if (redir) begin
                        pc_d   = tgt;
                        addr_d = tgt;
                        mis_d  = mis_q | tgt_mis;
                    end
                end
            end

            S_FAULT: begin
            end

            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    assign imem_req    = (state_q == S_FETCH);
    assign imem_addr   = addr_q;
    assign instr_valid = (state_q == S_DELIVER);
    assign instr       = instr_q;
    assign instr_pc    = ipc_q;
    assign misalign    = mis_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Device under test with default parameters.
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        misalign;
    logic        fault;

    fetch_sequencer #(.ADDR_W(32), .RESET_ADDR(32'h0), .MAX_WAIT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .stall(stall), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .misalign(misalign), .fault(fault)
    );

    // Second instance whose reset address sits just below the wrap point.
    logic        rst2_n;
    logic        req2;
    logic [31:0] addr2;
    logic        ack2;
    logic [31:0] rdata2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] ipc2;
    logic        mis2;
    logic        fault2;

    fetch_sequencer #(.ADDR_W(32), .RESET_ADDR(32'hFFFF_FFFC), .MAX_WAIT(15)) dut_wrap (
        .clk(clk), .rst_n(rst2_n),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ack(ack2), .imem_rdata(rdata2),
        .instr_valid(valid2), .instr(instr2), .instr_pc(ipc2),
        .stall(1'b0), .jump(1'b0), .jump_target(32'h0),
        .branch_taken(1'b0), .branch_target(32'h0),
        .misalign(mis2), .fault(fault2)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic a, input logic [31:0] d, input logic s,
                         input logic j, input logic [31:0] jt,
                         input logic b, input logic [31:0] bt);
        imem_ack      = a;
        imem_rdata    = d;
        stall         = s;
        jump          = j;
        jump_target   = jt;
        branch_taken  = b;
        branch_target = bt;
    endtask

    // Leaves the bench at a negedge with rst_n just released (DUT in BOOT).
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        chk("rst_req",   {31'h0, imem_req},    32'h0);
        chk("rst_addr",  imem_addr,            32'h0);
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_instr", instr,                32'h0);
        chk("rst_ipc",   instr_pc,             32'h0);
        chk("rst_mis",   {31'h0, misalign},    32'h0);
        chk("rst_fault", {31'h0, fault},       32'h0);
        rst_n = 1'b1;
    endtask

    // Directed vectors: expected outputs observed now, then inputs applied
    // for the following rising edge.
    typedef struct {
        logic        ack;
        logic [31:0] rdata;
        logic        stall;
        logic        jump;
        logic [31:0] jt;
        logic        br;
        logic [31:0] bt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
        logic        e_mis;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic a, logic [31:0] d, logic s, logic j, logic [31:0] jt,
                                logic b, logic [31:0] bt, logic er, logic [31:0] ea,
                                logic ev, logic [31:0] ei, logic [31:0] ep, logic em);
        vec_t v;
        v.ack = a; v.rdata = d; v.stall = s; v.jump = j; v.jt = jt; v.br = b; v.bt = bt;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_instr = ei; v.e_ipc = ep; v.e_mis = em;
        return v;
    endfunction

    // Behavioural reference: the fetcher is either booting, waiting on
    // memory, holding a delivered word, or dead after a timeout.
    bit          m_boot, m_hold, m_dead, m_discard, m_mis;
    logic [31:0] m_pc, m_bus, m_instr, m_ipc;
    int unsigned m_waits;

    task automatic model_init(input logic [31:0] start);
        m_boot = 1; m_hold = 0; m_dead = 0; m_discard = 0; m_mis = 0;
        m_pc = start; m_bus = start; m_instr = 0; m_ipc = 0; m_waits = 0;
    endtask

    task automatic model_step(input logic a, input logic [31:0] d, input logic s,
                              input logic j, input logic [31:0] jt,
                              input logic b, input logic [31:0] bt);
        bit          want;
        logic [31:0] dest;
        want = j | b;
        dest = j ? jt : bt;
        if (m_dead) return;
        if (m_boot) begin
            m_boot = 0; m_waits = 0;
        end else if (m_hold) begin
            if (!s) begin
                m_hold = 0; m_waits = 0;
                if (want) begin
                    m_pc = dest & ~32'd3; m_mis |= (dest % 4 != 0); m_bus = m_pc;
                end
            end
        end else if (a) begin
            m_waits = 0;
            if (m_discard || want) begin
                m_discard = 0;
                if (want) begin
                    m_pc = dest & ~32'd3; m_mis |= (dest % 4 != 0);
                end
                m_bus = m_pc;
            end else begin
                m_instr = d; m_ipc = m_pc; m_hold = 1;
                m_pc = m_pc + 4; m_bus = m_pc;
            end
        end else begin
            if (want) begin
                m_pc = dest & ~32'd3; m_mis |= (dest % 4 != 0); m_discard = 1;
            end
            m_waits++;
            if (m_waits == 15) m_dead = 1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        vec_t        v;

        rst2_n = 1'b0;
        ack2   = 1'b1;
        rdata2 = 32'h0;

        // ---------------- directed table ----------------
        //           ack dat          st j  jt           b  bt           req addr         v  instr        ipc          mis
        vq.push_back(mk(1, 32'h11,       0, 0, 0,          0, 0,          0, 32'h0,        0, 0,           0,           0));
        vq.push_back(mk(1, 32'hA0,       0, 0, 0,          0, 0,          1, 32'h0,        0, 0,           0,           0));
        vq.push_back(mk(1, 32'h0,        0, 0, 0,          0, 0,          0, 0,            1, 32'hA0,      32'h0,       0));
        vq.push_back(mk(1, 32'hA1,       0, 0, 0,          0, 0,          1, 32'h4,        0, 0,           0,           0));
        vq.push_back(mk(0, 32'h0,        0, 0, 0,          0, 0,          0, 0,            1, 32'hA1,      32'h4,       0));
        vq.push_back(mk(1, 32'hDEADBEEF, 0, 0, 0,          0, 0,          1, 32'h8,        0, 0,           0,           0));
        vq.push_back(mk(1, 32'h0,        1, 1, 32'h300,    0, 0,          0, 0,            1, 32'hDEADBEEF, 32'h8,      0));
        vq.push_back(mk(1, 32'h0,        1, 1, 32'h300,    0, 0,          0, 0,            1, 32'hDEADBEEF, 32'h8,      0));
        vq.push_back(mk(1, 32'h0,        1, 1, 32'h300,    0, 0,          0, 0,            1, 32'hDEADBEEF, 32'h8,      0));
        vq.push_back(mk(0, 32'h0,        0, 0, 0,          0, 0,          0, 0,            1, 32'hDEADBEEF, 32'h8,      0));
        vq.push_back(mk(1, 32'hB0,       0, 0, 0,          0, 0,          1, 32'hC,        0, 0,           0,           0));
        vq.push_back(mk(0, 32'h0,        0, 1, 32'h100,    1, 32'h200,    0, 0,            1, 32'hB0,      32'hC,       0));
        vq.push_back(mk(1, 32'hB1,       0, 0, 0,          0, 0,          1, 32'h100,      0, 0,           0,           0));
        vq.push_back(mk(0, 32'h0,        0, 0, 0,          1, 32'h203,    0, 0,            1, 32'hB1,      32'h100,     0));
        vq.push_back(mk(0, 32'h0,        0, 0, 0,          1, 32'h40,     1, 32'h200,      0, 0,           0,           1));
        vq.push_back(mk(0, 32'h0,        0, 0, 0,          0, 0,          1, 32'h200,      0, 0,           0,           1));
        vq.push_back(mk(0, 32'h0,        0, 0, 0,          0, 0,          1, 32'h200,      0, 0,           0,           1));
        vq.push_back(mk(1, 32'hDEAD0001, 0, 0, 0,          0, 0,          1, 32'h200,      0, 0,           0,           1));
        vq.push_back(mk(1, 32'hC0,       0, 0, 0,          0, 0,          1, 32'h40,       0, 0,           0,           1));
        vq.push_back(mk(0, 32'h0,        0, 0, 0,          0, 0,          0, 0,            1, 32'hC0,      32'h40,      1));
        vq.push_back(mk(1, 32'hEEEE,     0, 1, 32'h80,     0, 0,          1, 32'h44,       0, 0,           0,           1));
        vq.push_back(mk(1, 32'hC1,       0, 0, 0,          0, 0,          1, 32'h80,       0, 0,           0,           1));
        vq.push_back(mk(0, 32'h0,        0, 0, 0,          0, 0,          0, 0,            1, 32'hC1,      32'h80,      1));
        vq.push_back(mk(0, 32'h0,        0, 0, 0,          0, 0,          1, 32'h84,       0, 0,           0,           1));

        do_reset();
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            chk($sformatf("vec%0d_req", i), {31'h0, imem_req}, {31'h0, v.e_req});
            if (v.e_req) chk($sformatf("vec%0d_addr", i), imem_addr, v.e_addr);
            chk($sformatf("vec%0d_valid", i), {31'h0, instr_valid}, {31'h0, v.e_valid});
            if (v.e_valid) begin
                chk($sformatf("vec%0d_instr", i), instr, v.e_instr);
                chk($sformatf("vec%0d_ipc", i), instr_pc, v.e_ipc);
            end
            chk($sformatf("vec%0d_mis", i), {31'h0, misalign}, {31'h0, v.e_mis});
            chk($sformatf("vec%0d_fault", i), {31'h0, fault}, 32'h0);
            drive(v.ack, v.rdata, v.stall, v.jump, v.jt, v.br, v.bt);
            @(negedge clk);
        end

        // ---------------- randomized run against the model ----------------
        do_reset();
        model_init(32'h0);
        for (int c = 0; c < 1500; c++) begin
            logic        a, s, j, b;
            logic [31:0] d, jt, bt;
            bit          fetching;
            fetching = !m_boot && !m_hold && !m_dead;
            chk("rnd_req", {31'h0, imem_req}, {31'h0, fetching});
            if (fetching) chk("rnd_addr", imem_addr, m_bus);
            chk("rnd_valid", {31'h0, instr_valid}, {31'h0, m_hold});
            chk("rnd_instr", instr, m_instr);
            chk("rnd_ipc", instr_pc, m_ipc);
            chk("rnd_mis", {31'h0, misalign}, {31'h0, m_mis});
            chk("rnd_fault", {31'h0, fault}, {31'h0, m_dead});
            a  = ($urandom_range(0, 9) < 6);
            d  = $urandom;
            s  = ($urandom_range(0, 2) == 0);
            j  = ($urandom_range(0, 7) == 0);
            b  = ($urandom_range(0, 7) == 0);
            jt = {$urandom_range(0, 32'h3FFF), 2'b00} | (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            bt = {$urandom_range(0, 32'h3FFF), 2'b00} | (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            drive(a, d, s, j, jt, b, bt);
            model_step(a, d, s, j, jt, b, bt);
            @(negedge clk);
        end

        // ---------------- PC wrap from 0xFFFFFFFC ----------------
        chk("wrap_rst_addr", addr2, 32'hFFFF_FFFC);
        rdata2 = 32'h1234_5678;
        rst2_n = 1'b1;
        @(negedge clk);                          // FETCH
        chk("wrap_req1", {31'h0, req2}, 32'h1);
        chk("wrap_addr1", addr2, 32'hFFFF_FFFC);
        @(negedge clk);                          // DELIVER
        chk("wrap_valid1", {31'h0, valid2}, 32'h1);
        chk("wrap_ipc1", ipc2, 32'hFFFF_FFFC);
        chk("wrap_instr1", instr2, 32'h1234_5678);
        rdata2 = 32'h9ABC_DEF0;
        @(negedge clk);                          // FETCH at wrapped address
        chk("wrap_req2", {31'h0, req2}, 32'h1);
        chk("wrap_addr2", addr2, 32'h0);
        @(negedge clk);
        chk("wrap_ipc2", ipc2, 32'h0);
        chk("wrap_instr2", instr2, 32'h9ABC_DEF0);
        rst2_n = 1'b0;

        // ---------------- timeout and async reset ----------------
        do_reset();
        n = 0;
        for (int c = 0; c < 40 && !fault; c++) begin
            if (imem_req) n++;
            @(negedge clk);
        end
        chk("tmo_fault", {31'h0, fault}, 32'h1);
        chk("tmo_cycles", n, 32'd15);
        chk("tmo_req", {31'h0, imem_req}, 32'h0);
        chk("tmo_valid", {31'h0, instr_valid}, 32'h0);
        drive(1'b1, 32'h5555, 1'b0, 1'b1, 32'h400, 1'b1, 32'h801);
        repeat (3) @(negedge clk);
        chk("fault_hold", {31'h0, fault}, 32'h1);
        chk("fault_req", {31'h0, imem_req}, 32'h0);
        chk("fault_mis", {31'h0, misalign}, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_fault", {31'h0, fault}, 32'h0);
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", {31'h0, instr_valid}, 32'h0);
        chk("arst_instr", instr, 32'h0);
        chk("arst_ipc", instr_pc, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
